dit4_butterfly_round: RTL and testbench

Radix-4 decimation-in-time butterfly with rescale. It sits directly downstream of the merge stage's X0 alignment path and the three twiddle multipliers. It consumes four complex operands on the common product scale: X0 pre-shifted by SHIFT, and X1..X3 already multiplied by their twiddles. It forms the four radix-4 outputs, rounds away the SHIFT fractional bits, saturates to OUT_WIDTH, and tags frame boundaries for the next FFT stage.

---
 rtl/dit4_butterfly_round.sv | 201 ++++++++++++++++++++
 tb/tb_dit4_butterfly_round.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dit4_butterfly_round.sv
// Radix-4 decimation-in-time butterfly on product-scale operands, followed by
// round-half-up rescale, saturation to OUT_WIDTH and frame-boundary tagging.
module dit4_butterfly_round #(
    parameter int  DATA_WIDTH = 21,
    parameter int  TWID_WIDTH = 16,
    parameter int  SHIFT      = 15,
    parameter int  OUT_WIDTH  = 23,
    parameter int  FRAME_LEN  = 64,
    localparam int PROD_W     = DATA_WIDTH + TWID_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [PROD_W-1:0]    x0_r,
    input  logic signed [PROD_W-1:0]    x0_i,
    input  logic signed [PROD_W-1:0]    x1_r,
    input  logic signed [PROD_W-1:0]    x1_i,
    input  logic signed [PROD_W-1:0]    x2_r,
    input  logic signed [PROD_W-1:0]    x2_i,
    input  logic signed [PROD_W-1:0]    x3_r,
    input  logic signed [PROD_W-1:0]    x3_i,
    input  logic                        sat_clr,
    output logic signed [OUT_WIDTH-1:0] y0_r,
    output logic signed [OUT_WIDTH-1:0] y0_i,
    output logic signed [OUT_WIDTH-1:0] y1_r,
    output logic signed [OUT_WIDTH-1:0] y1_i,
    output logic signed [OUT_WIDTH-1:0] y2_r,
    output logic signed [OUT_WIDTH-1:0] y2_i,
    output logic signed [OUT_WIDTH-1:0] y3_r,
    output logic signed [OUT_WIDTH-1:0] y3_i,
    output logic                        out_valid,
    output logic                        out_last,
    output logic                        sat_flag
);

    localparam int S1_W  = PROD_W + 1;
    localparam int S2_W  = PROD_W + 2;
    localparam int BI_W  = S2_W + 1;
    localparam int SH_W  = BI_W - SHIFT;
    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    localparam logic [BI_W-1:0]      HALF     = {{(BI_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX  = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN  = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    function automatic logic [S1_W-1:0] ext_p(input logic [PROD_W-1:0] v);
        return {v[PROD_W-1], v};
    endfunction

    function automatic logic [S2_W-1:0] ext_s1(input logic [S1_W-1:0] v);
        return {v[S1_W-1], v};
    endfunction

    // Bias by half an output LSB, drop SHIFT bits, clamp; result MSB flags a clamp.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic [S2_W-1:0] v);
        logic [BI_W-1:0]           biased;
        logic [SH_W-1:0]           shifted;
        logic [SH_W-OUT_WIDTH:0]   top;
        biased  = {v[S2_W-1], v} + HALF;
        shifted = biased[BI_W-1:SHIFT];
        top     = shifted[SH_W-1:OUT_WIDTH-1];
        if ((&top) || (~|top)) begin
            return {1'b0, shifted[OUT_WIDTH-1:0]};
        end else if (shifted[SH_W-1]) begin
            return {1'b1, OUT_MIN};
        end else begin
            return {1'b1, OUT_MAX};
        end
    endfunction

    // Stage 1 state: a = x0+x2, b = x0-x2, c = x1+x3, d = x1-x3
    logic [S1_W-1:0] a_r_d, a_i_d, b_r_d, b_i_d, c_r_d, c_i_d, d_r_d, d_i_d;
    logic [S1_W-1:0] a_r_q, a_i_q, b_r_q, b_i_q, c_r_q, c_i_q, d_r_q, d_i_q;
    logic            v1_q;

    // Stage 2 state, ordered y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i
    logic [S2_W-1:0] y_d [8];
    logic [S2_W-1:0] y_q [8];
    logic            v2_q;

    // Stage 3 / output state
    logic [OUT_WIDTH:0]   round_s [8];
    logic [7:0]           sat_vec_s;
    logic [OUT_WIDTH-1:0] out_d [8];
    logic [OUT_WIDTH-1:0] out_q [8];
    logic                 out_valid_d, out_valid_q;
    logic                 out_last_d, out_last_q;
    logic                 sat_d, sat_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    // Stage 1 sums and differences
    always_comb begin
        a_r_d = ext_p(x0_r) + ext_p(x2_r);
        a_i_d = ext_p(x0_i) + ext_p(x2_i);
        b_r_d = ext_p(x0_r) - ext_p(x2_r);
        b_i_d = ext_p(x0_i) - ext_p(x2_i);
        c_r_d = ext_p(x1_r) + ext_p(x3_r);
        c_i_d = ext_p(x1_i) + ext_p(x3_i);
        d_r_d = ext_p(x1_r) - ext_p(x3_r);
        d_i_d = ext_p(x1_i) - ext_p(x3_i);
    end

    // Stage 2: y1 = b - j*d and y3 = b + j*d fold the -j rotation into swaps
    always_comb begin
        y_d[0] = ext_s1(a_r_q) + ext_s1(c_r_q);
        y_d[1] = ext_s1(a_i_q) + ext_s1(c_i_q);
        y_d[2] = ext_s1(b_r_q) + ext_s1(d_i_q);
        y_d[3] = ext_s1(b_i_q) - ext_s1(d_r_q);
        y_d[4] = ext_s1(a_r_q) - ext_s1(c_r_q);
        y_d[5] = ext_s1(a_i_q) - ext_s1(c_i_q);
        y_d[6] = ext_s1(b_r_q) - ext_s1(d_i_q);
        y_d[7] = ext_s1(b_i_q) + ext_s1(d_r_q);
    end

    // Stage 3 rescale plus frame counter and sticky saturation flag
    always_comb begin
        sat_vec_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            round_s[i]   = round_sat(y_q[i]);
            out_d[i]     = round_s[i][OUT_WIDTH-1:0];
            sat_vec_s[i] = round_s[i][OUT_WIDTH];
        end
        out_valid_d = v2_q;
        out_last_d  = 1'b0;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        if (v2_q) begin
            out_last_d = (cnt_q == LAST_IDX);
            cnt_d      = cnt_q + CNT_ONE;
        end else begin
            out_last_d = 1'b0;
            cnt_d      = cnt_q;
        end
        // A new saturation beats a simultaneous clear.
        if (v2_q && (|sat_vec_s)) begin
            sat_d = 1'b1;
        end else if (sat_clr) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end
    end

    // Pipeline registers; data loads every cycle, valid travels alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r_q       <= '0;
            a_i_q       <= '0;
            b_r_q       <= '0;
            b_i_q       <= '0;
            c_r_q       <= '0;
            c_i_q       <= '0;
            d_r_q       <= '0;
            d_i_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i < 8; i++) begin
                y_q[i]   <= '0;
                out_q[i] <= '0;
            end
        end else begin
            a_r_q       <= a_r_d;
            a_i_q       <= a_i_d;
            b_r_q       <= b_r_d;
            b_i_q       <= b_i_d;
            c_r_q       <= c_r_d;
            c_i_q       <= c_i_d;
            d_r_q       <= d_r_d;
            d_i_q       <= d_i_d;
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            for (int i = 0; i < 8; i++) begin
                y_q[i]   <= y_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

    assign y0_r      = out_q[0];
    assign y0_i      = out_q[1];
    assign y1_r      = out_q[2];
    assign y1_i      = out_q[3];
    assign y2_r      = out_q[4];
    assign y2_i      = out_q[5];
    assign y3_r      = out_q[6];
    assign y3_i      = out_q[7];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_dit4_butterfly_round.sv
// Self-checking bench for dit4_butterfly_round: randomized butterflies against a
// plain-arithmetic radix-4 model, plus hand-computed directed cases.
module tb_dit4_butterfly_round;

    localparam int PW = 38;
    localparam int OW = 23;
    localparam int SH = 15;
    localparam int FL = 64;
    localparam longint OMAX  = (longint'(1) <<< (OW - 1)) - 1;
    localparam longint OMIN  = -(longint'(1) <<< (OW - 1));
    localparam longint HALFL = longint'(1) <<< (SH - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic sat_clr = 1'b0;
    logic signed [PW-1:0] x [8];
    logic signed [OW-1:0] y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i;
    logic out_valid, out_last, sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: three-deep pipeline of sampled inputs
    bit     pv [3];
    longint px [3][8];
    bit     plast [3];
    int     mcnt = 0;
    bit     msat = 1'b0;
    int     ov_count = 0;
    int     last_count = 0;
    int     first_last_idx = -1;
    longint zeros [8];
    string  yn [8] = '{"y0_r", "y0_i", "y1_r", "y1_i", "y2_r", "y2_i", "y3_r", "y3_i"};

    dit4_butterfly_round dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .x0_r(x[0]), .x0_i(x[1]), .x1_r(x[2]), .x1_i(x[3]),
        .x2_r(x[4]), .x2_i(x[5]), .x3_r(x[6]), .x3_i(x[7]),
        .sat_clr(sat_clr),
        .y0_r(y0_r), .y0_i(y0_i), .y1_r(y1_r), .y1_i(y1_i),
        .y2_r(y2_r), .y2_i(y2_i), .y3_r(y3_r), .y3_i(y3_i),
        .out_valid(out_valid), .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic longint rnd_sat(input longint v, output bit s);
        longint r;
        r = (v + HALFL) >>> SH;
        s = 1'b0;
        if (r > OMAX) begin
            s = 1'b1;
            r = OMAX;
        end else if (r < OMIN) begin
            s = 1'b1;
            r = OMIN;
        end
        return r;
    endfunction

    // y_k = sum_n x_n * (-j)^(n*k), written out per component
    function automatic void model(input longint xs[8], output longint ys[8], output bit s);
        longint p [8];
        bit     t;
        p[0] = xs[0] + xs[2] + xs[4] + xs[6];
        p[1] = xs[1] + xs[3] + xs[5] + xs[7];
        p[2] = xs[0] + xs[3] - xs[4] - xs[7];
        p[3] = xs[1] - xs[2] - xs[5] + xs[6];
        p[4] = xs[0] - xs[2] + xs[4] - xs[6];
        p[5] = xs[1] - xs[3] + xs[5] - xs[7];
        p[6] = xs[0] - xs[3] - xs[4] + xs[7];
        p[7] = xs[1] + xs[2] - xs[5] - xs[6];
        s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ys[i] = rnd_sat(p[i], t);
            s = s | t;
        end
    endfunction

    function automatic longint yval(input int i);
        case (i)
            0: return longint'(y0_r);
            1: return longint'(y0_i);
            2: return longint'(y1_r);
            3: return longint'(y1_i);
            4: return longint'(y2_r);
            5: return longint'(y2_i);
            6: return longint'(y3_r);
            default: return longint'(y3_i);
        endcase
    endfunction

    // reference model advances on every rising edge
    initial forever begin
        longint ys [8];
        bit     s;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i] = 1'b0;
                plast[i] = 1'b0;
            end
            mcnt = 0;
            msat = 1'b0;
            ov_count = 0;
            last_count = 0;
            first_last_idx = -1;
        end else begin
            plast[1] = 1'b0;
            if (pv[1]) begin
                model(px[1], ys, s);
                plast[1] = (mcnt == FL - 1);
                mcnt = (mcnt + 1) % FL;
                if (s) msat = 1'b1;
                else if (sat_clr) msat = 1'b0;
            end else if (sat_clr) begin
                msat = 1'b0;
            end
            pv[2] = pv[1];
            plast[2] = plast[1];
            pv[1] = pv[0];
            for (int i = 0; i < 8; i++) begin
                px[2][i] = px[1][i];
                px[1][i] = px[0][i];
                px[0][i] = longint'(x[i]);
            end
            pv[0] = in_valid;
        end
    end

    // compare process, away from the active edge
    initial forever begin
        longint ys [8];
        bit     s;
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", longint'(out_valid), longint'(pv[2]));
            chk("out_last", longint'(out_last), longint'(pv[2] && plast[2]));
            chk("sat_flag", longint'(sat_flag), longint'(msat));
            if (pv[2]) begin
                model(px[2], ys, s);
                for (int i = 0; i < 8; i++) chk(yn[i], yval(i), ys[i]);
            end
            if (out_valid) begin
                if (out_last) begin
                    if (last_count == 0) first_last_idx = ov_count;
                    last_count++;
                end
                ov_count++;
            end
        end
    end

    task automatic put(input bit v, input longint xs[8]);
        @(negedge clk);
        #1;
        in_valid = v;
        for (int i = 0; i < 8; i++) x[i] = xs[i][PW-1:0];
    endtask

    // one valid butterfly; returns at the falling edge where its result is shown
    task automatic fire(input longint xs[8]);
        put(1'b1, xs);
        put(1'b0, zeros);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic rnd_vec(output longint xs[8]);
        int mode;
        mode = $urandom_range(0, 3);
        for (int i = 0; i < 8; i++) begin
            xs[i] = {$urandom, $urandom};
            if (mode == 0) xs[i] = (xs[i] <<< 26) >>> 26;
            else if (mode == 1) xs[i] = (xs[i] <<< 28) >>> 28;
            else xs[i] = (xs[i] <<< 38) >>> 38;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sat_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        longint v [8];
        longint e [8];
        for (int i = 0; i < 8; i++) begin
            zeros[i] = 0;
            x[i] = '0;
        end
        #3;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_y0_r", longint'(y0_r), 0);
        chk("rst_y3_i", longint'(y3_i), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // impulse on x0_r
        v = zeros;
        v[0] = 100 * 32768;
        fire(v);
        chk("imp_valid", longint'(out_valid), 1);
        e = '{100, 0, 100, 0, 100, 0, 100, 0};
        for (int i = 0; i < 8; i++) chk({"imp_", yn[i]}, yval(i), e[i]);

        // sign pattern from x1_i
        v = zeros;
        v[3] = 5 * 32768;
        fire(v);
        e = '{0, 5, 5, 0, 0, -5, -5, 0};
        for (int i = 0; i < 8; i++) chk({"sign_", yn[i]}, yval(i), e[i]);

        // rounding
        v = zeros;
        v[0] = 3 * 16384;
        fire(v);
        chk("round_p1p5", longint'(y0_r), 2);
        v[0] = -3 * 16384;
        fire(v);
        chk("round_m1p5", longint'(y0_r), -1);
        v[0] = 16383;
        fire(v);
        chk("round_below_half", longint'(y0_r), 0);
        chk("sat_before", longint'(sat_flag), 0);

        // saturation and the sticky flag
        v = zeros;
        v[0] = longint'(1) <<< 36;
        v[3] = longint'(1) <<< 36;
        v[4] = -(longint'(1) <<< 36);
        v[7] = -(longint'(1) <<< 36);
        fire(v);
        chk("sat_y1_r", longint'(y1_r), 4194303);
        chk("sat_y0_r", longint'(y0_r), 0);
        chk("sat_rise", longint'(sat_flag), 1);
        v = zeros;
        v[0] = 7 * 32768;
        fire(v);
        chk("sat_sticky", longint'(sat_flag), 1);
        chk("clean_y2_r", longint'(y2_r), 7);
        @(negedge clk);
        #1;
        sat_clr = 1'b1;
        @(negedge clk);
        chk("sat_cleared", longint'(sat_flag), 0);
        #1;
        sat_clr = 1'b0;

        // randomized traffic with bubbles and occasional clears
        for (int n = 0; n < 400; n++) begin
            rnd_vec(v);
            put($urandom_range(0, 9) < 7, v);
            sat_clr = ($urandom_range(0, 7) == 0);
        end
        put(1'b0, zeros);
        sat_clr = 1'b0;
        repeat (5) put(1'b0, zeros);

        // one full frame with gaps, then three more butterflies
        do_reset();
        for (int n = 0; n < FL + 3; n++) begin
            repeat ($urandom_range(0, 2)) begin
                rnd_vec(v);
                put(1'b0, v);
            end
            rnd_vec(v);
            put(1'b1, v);
        end
        repeat (6) put(1'b0, zeros);
        chk("frame_outputs", ov_count, FL + 3);
        chk("frame_last_count", last_count, 1);
        chk("frame_last_index", first_last_idx, FL - 1);

        // reset with two butterflies in flight
        do_reset();
        for (int n = 0; n < 10; n++) begin
            rnd_vec(v);
            put(1'b1, v);
        end
        do_reset();
        repeat (5) put(1'b0, zeros);
        chk("flush_no_valid", ov_count, 0);
        for (int n = 0; n < FL; n++) begin
            rnd_vec(v);
            put(1'b1, v);
        end
        repeat (6) put(1'b0, zeros);
        chk("postrst_outputs", ov_count, FL);
        chk("postrst_last_count", last_count, 1);
        chk("postrst_last_index", first_last_idx, FL - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
